// File: rtl/counter_pkg.sv
// Shared types and sizing helpers for the display counter sequencer.
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int COUNT_W = 8;

  // Prescaler width; never below one bit so a two-cycle divider still has a register.
  function automatic int presc_w(input int clk_div);
    return (clk_div > 2) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for a debounced, already-synchronous button level.
module btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic level,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) prev <= 1'b0;
    else     prev <= level;
  end

  assign pulse = level & ~prev;

endmodule

// File: rtl/counter_sequencer.sv
// Run/pause/step/clear sequencer driving the display counter from a prescaled main clock.
module counter_sequencer
  import counter_pkg::*;
#(
  parameter int CLK_DIV = 100_000_000,
  parameter int WIDTH   = COUNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_start,
  input  logic             btn_stop,
  input  logic             btn_step,
  input  logic             btn_clear,
  input  logic             dir,
  input  logic             auto_reload,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             running,
  output logic             done
);

  localparam int            PW         = presc_w(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  state_t           state, state_n;
  logic [PW-1:0]    presc, presc_n;
  logic [WIDTH-1:0] count_n;
  logic             tick_n;

  logic             start_p, stop_p, step_p, clr_p;

  logic [WIDTH-1:0] step_count;
  logic             step_tick;
  logic             step_done;
  logic             take_step;

  btn_edge u_edge_start (.clk(clk), .rst(rst), .level(btn_start), .pulse(start_p));
  btn_edge u_edge_stop  (.clk(clk), .rst(rst), .level(btn_stop),  .pulse(stop_p));
  btn_edge u_edge_step  (.clk(clk), .rst(rst), .level(btn_step),  .pulse(step_p));
  btn_edge u_edge_clear (.clk(clk), .rst(rst), .level(btn_clear), .pulse(clr_p));

  // Result of one count step; a non-reloading terminal step holds count and requests DONE.
  always_comb begin
    step_count = count;
    step_tick  = 1'b0;
    step_done  = 1'b0;
    if (dir) begin
      if (count == limit) begin
        if (auto_reload) begin
          step_count = '0;
          step_tick  = 1'b1;
        end else begin
          step_done = 1'b1;
        end
      end else begin
        step_count = count + WIDTH'(1);
        step_tick  = 1'b1;
      end
    end else begin
      if (count == '0) begin
        if (auto_reload) begin
          step_count = limit;
          step_tick  = 1'b1;
        end else begin
          step_done = 1'b1;
        end
      end else begin
        step_count = count - WIDTH'(1);
        step_tick  = 1'b1;
      end
    end
  end

  // A stop pulse masks start and step in every state, which gives the clear > stop > start > step order.
  always_comb begin
    state_n   = state;
    count_n   = count;
    presc_n   = presc;
    tick_n    = 1'b0;
    take_step = 1'b0;

    if (clr_p) begin
      state_n = ST_IDLE;
      count_n = '0;
      presc_n = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!stop_p) begin
            if (start_p) begin
              state_n = ST_RUN;
              presc_n = '0;
            end else if (step_p) begin
              take_step = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (stop_p) begin
            state_n = ST_PAUSE;
          end else if (presc == PRESC_LAST) begin
            presc_n   = '0;
            take_step = 1'b1;
          end else begin
            presc_n = presc + PW'(1);
          end
        end
        ST_PAUSE: begin
          if (!stop_p) begin
            if (start_p) begin
              state_n = ST_RUN;
            end else if (step_p) begin
              take_step = 1'b1;
            end
          end
        end
        ST_DONE: begin
          if (!stop_p && start_p) begin
            count_n = dir ? '0 : limit;
            presc_n = '0;
            state_n = ST_RUN;
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end

    if (take_step) begin
      count_n = step_count;
      tick_n  = step_tick;
      if (step_done) state_n = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      presc   <= '0;
      count   <= '0;
      tick    <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      presc   <= presc_n;
      count   <= count_n;
      tick    <= tick_n;
      running <= (state_n == ST_RUN);
      done    <= (state_n == ST_DONE);
    end
  end

endmodule

// File: tb/tb_counter_sequencer.sv
// Scenario bench for counter_sequencer with CLK_DIV=4; expected counts queued and popped on each tick.
module tb_counter_sequencer;

  localparam int CLK_DIV = 4;
  localparam int WIDTH   = 8;
  localparam int B_START = 0;
  localparam int B_STOP  = 1;
  localparam int B_STEP  = 2;
  localparam int B_CLEAR = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             btn_start = 1'b0;
  logic             btn_stop = 1'b0;
  logic             btn_step = 1'b0;
  logic             btn_clear = 1'b0;
  logic             dir = 1'b1;
  logic             auto_reload = 1'b1;
  logic [WIDTH-1:0] limit = 8'd5;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             running;
  logic             done;

  int         pass_cnt = 0;
  int         total_cnt = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  counter_sequencer #(.CLK_DIV(CLK_DIV), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .btn_start(btn_start), .btn_stop(btn_stop), .btn_step(btn_step), .btn_clear(btn_clear),
    .dir(dir), .auto_reload(auto_reload), .limit(limit),
    .count(count), .tick(tick), .running(running), .done(done)
  );

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Raise one button at a negedge; the action lands on the next posedge and is visible on return.
  task automatic press(input int which);
    case (which)
      B_START: btn_start = 1'b1;
      B_STOP:  btn_stop  = 1'b1;
      B_STEP:  btn_step  = 1'b1;
      B_CLEAR: btn_clear = 1'b1;
      default: ;
    endcase
    @(negedge clk);
    btn_start = 1'b0;
    btn_stop  = 1'b0;
    btn_step  = 1'b0;
    btn_clear = 1'b0;
  endtask

  task automatic wait_tick(input int budget, output int cycles, output bit seen);
    seen   = 1'b0;
    cycles = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (tick) seen = 1'b1;
    end
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit seen, output int ticks);
    seen   = 1'b0;
    cycles = 0;
    ticks  = 0;
    while (!seen && cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (tick) ticks++;
      if (done) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total_cnt++; if (count !== 8'd0) $display("[TB] FAIL reset_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (tick !== 1'b0) $display("[TB] FAIL reset_tick: got %b expected 0", tick); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("[TB] FAIL reset_running: got %b expected 0", running); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_run_up();
    int cyc; bit seen; logic [7:0] e;
    dir = 1'b1; limit = 8'd5; auto_reload = 1'b1;
    press(B_START);
    total_cnt++; if (running !== 1'b1) $display("[TB] FAIL run_enter: running=%b expected 1", running); else pass_cnt++;
    foreach (exp_q[i]) ;
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3); exp_q.push_back(8'd4);
    exp_q.push_back(8'd5); exp_q.push_back(8'd0); exp_q.push_back(8'd1);
    for (int k = 0; k < 7; k++) begin
      wait_tick(10, cyc, seen);
      total_cnt++; if (!seen) begin $display("[TB] FAIL run_tick_timeout[%0d]: no tick within 10 cycles", k); continue; end else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL run_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
      total_cnt++; if (cyc !== 4) $display("[TB] FAIL run_spacing[%0d]: got %0d cycles expected 4", k, cyc); else pass_cnt++;
      total_cnt++; if (running !== 1'b1) $display("[TB] FAIL run_running[%0d]: got %b expected 1", k, running); else pass_cnt++;
    end
    exp_q.delete();
  endtask

  task automatic test_terminal_stop();
    int cyc; int ticks; bit seen; logic [7:0] e;
    press(B_CLEAR);
    @(negedge clk);
    auto_reload = 1'b0; limit = 8'd3; dir = 1'b1;
    press(B_START);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2); exp_q.push_back(8'd3);
    for (int k = 0; k < 3; k++) begin
      wait_tick(10, cyc, seen);
      total_cnt++; if (!seen) begin $display("[TB] FAIL term_tick_timeout[%0d]: no tick", k); continue; end else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL term_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
    end
    wait_done(10, cyc, seen, ticks);
    total_cnt++; if (!seen) $display("[TB] FAIL term_done: done never asserted"); else pass_cnt++;
    total_cnt++; if (cyc !== 4) $display("[TB] FAIL term_done_delay: got %0d cycles expected 4", cyc); else pass_cnt++;
    total_cnt++; if (ticks !== 0) $display("[TB] FAIL term_no_tick: got %0d ticks expected 0", ticks); else pass_cnt++;
    total_cnt++; if (count !== 8'd3) $display("[TB] FAIL term_hold: got %0d expected 3", count); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("[TB] FAIL term_running: got %b expected 0", running); else pass_cnt++;
    press(B_START);
    total_cnt++; if (count !== 8'd0) $display("[TB] FAIL reload_count: got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (tick !== 1'b0) $display("[TB] FAIL reload_tick: got %b expected 0", tick); else pass_cnt++;
    total_cnt++; if (running !== 1'b1 || done !== 1'b0) $display("[TB] FAIL reload_state: running=%b done=%b expected 1/0", running, done); else pass_cnt++;
    exp_q.push_back(8'd1);
    wait_tick(10, cyc, seen);
    total_cnt++; if (!seen || cyc !== 4) $display("[TB] FAIL reload_first_tick: seen=%b cycles=%0d expected 1/4", seen, cyc); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (count !== e) $display("[TB] FAIL reload_next: got %0d expected %0d", count, e); else pass_cnt++;
  endtask

  task automatic test_down_count();
    int cyc; int ticks; bit seen; logic [7:0] e;
    press(B_CLEAR);
    @(negedge clk);
    dir = 1'b0; limit = 8'd9; auto_reload = 1'b1;
    press(B_START);
    exp_q.push_back(8'd9); exp_q.push_back(8'd8); exp_q.push_back(8'd7);
    for (int k = 0; k < 3; k++) begin
      wait_tick(10, cyc, seen);
      total_cnt++; if (!seen) begin $display("[TB] FAIL down_tick_timeout[%0d]: no tick", k); continue; end else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL down_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
    end
    press(B_CLEAR);
    @(negedge clk);
    dir = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      exp_q.push_back(8'(k));
      press(B_STEP);
      total_cnt++; if (tick !== 1'b1) $display("[TB] FAIL idle_step_tick[%0d]: got %b expected 1", k, tick); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL idle_step_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
      @(negedge clk);
    end
    dir = 1'b0; auto_reload = 1'b0;
    press(B_START);
    exp_q.push_back(8'd1); exp_q.push_back(8'd0);
    for (int k = 0; k < 2; k++) begin
      wait_tick(10, cyc, seen);
      total_cnt++; if (!seen) begin $display("[TB] FAIL down_stop_timeout[%0d]: no tick", k); continue; end else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL down_stop_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
    end
    wait_done(10, cyc, seen, ticks);
    total_cnt++; if (!seen || ticks !== 0) $display("[TB] FAIL down_done: seen=%b ticks=%0d expected 1/0", seen, ticks); else pass_cnt++;
    total_cnt++; if (count !== 8'd0) $display("[TB] FAIL down_done_count: got %0d expected 0", count); else pass_cnt++;
    // limit of zero counting up: the very first step is terminal
    press(B_CLEAR);
    @(negedge clk);
    dir = 1'b1; limit = 8'd0; auto_reload = 1'b0;
    press(B_STEP);
    total_cnt++; if (done !== 1'b1) $display("[TB] FAIL zero_limit_done: got %b expected 1", done); else pass_cnt++;
    total_cnt++; if (tick !== 1'b0 || count !== 8'd0) $display("[TB] FAIL zero_limit_hold: tick=%b count=%0d expected 0/0", tick, count); else pass_cnt++;
  endtask

  task automatic test_pause_step();
    int cyc; int ticks; bit seen; logic [7:0] e;
    press(B_CLEAR);
    @(negedge clk);
    dir = 1'b1; limit = 8'd200; auto_reload = 1'b1;
    press(B_START);
    exp_q.push_back(8'd1);
    wait_tick(10, cyc, seen);
    total_cnt++; if (!seen) $display("[TB] FAIL pause_first_tick: no tick"); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (count !== e) $display("[TB] FAIL pause_first_count: got %0d expected %0d", count, e); else pass_cnt++;
    repeat (2) @(negedge clk);
    press(B_STOP);
    total_cnt++; if (running !== 1'b0) $display("[TB] FAIL pause_running: got %b expected 0", running); else pass_cnt++;
    ticks = 0;
    repeat (6) begin @(negedge clk); if (tick) ticks++; end
    total_cnt++; if (ticks !== 0 || count !== 8'd1) $display("[TB] FAIL pause_frozen: ticks=%0d count=%0d expected 0/1", ticks, count); else pass_cnt++;
    for (int k = 2; k <= 3; k++) begin
      exp_q.push_back(8'(k));
      press(B_STEP);
      total_cnt++; if (tick !== 1'b1) $display("[TB] FAIL pause_step_tick[%0d]: got %b expected 1", k, tick); else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL pause_step_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
      @(negedge clk);
    end
    press(B_START);
    total_cnt++; if (running !== 1'b1) $display("[TB] FAIL resume_running: got %b expected 1", running); else pass_cnt++;
    exp_q.push_back(8'd4);
    wait_tick(10, cyc, seen);
    total_cnt++; if (!seen || cyc !== 2) $display("[TB] FAIL resume_phase: seen=%b cycles=%0d expected 1/2", seen, cyc); else pass_cnt++;
    e = exp_q.pop_front();
    total_cnt++; if (count !== e) $display("[TB] FAIL resume_count: got %0d expected %0d", count, e); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    int ticks; logic [7:0] e;
    btn_clear = 1'b1; btn_start = 1'b1;
    @(negedge clk);
    btn_clear = 1'b0; btn_start = 1'b0;
    total_cnt++; if (count !== 8'd0 || tick !== 1'b0) $display("[TB] FAIL clr_start_count: count=%0d tick=%b expected 0/0", count, tick); else pass_cnt++;
    total_cnt++; if (running !== 1'b0 || done !== 1'b0) $display("[TB] FAIL clr_start_idle: running=%b done=%b expected 0/0", running, done); else pass_cnt++;
    @(negedge clk);
    exp_q.push_back(8'd1); exp_q.push_back(8'd2);
    ticks = 0;
    btn_start = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (tick) begin
        ticks++;
        total_cnt++;
        if (exp_q.size() == 0) $display("[TB] FAIL hold_unexpected_tick: count=%0d with empty queue", count);
        else begin
          e = exp_q.pop_front();
          if (count !== e) $display("[TB] FAIL hold_count: got %0d expected %0d", count, e); else pass_cnt++;
        end
      end
      if (i == 1) begin
        total_cnt++; if (running !== 1'b1) $display("[TB] FAIL hold_start: running=%b expected 1", running); else pass_cnt++;
      end
      if (i == 10) btn_stop = 1'b1;
      if (i == 11) btn_stop = 1'b0;
    end
    total_cnt++; if (ticks !== 2) $display("[TB] FAIL hold_ticks: got %0d expected 2", ticks); else pass_cnt++;
    total_cnt++; if (running !== 1'b0) $display("[TB] FAIL hold_single_start: running=%b expected 0", running); else pass_cnt++;
    btn_start = 1'b0;
    exp_q.delete();
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int cyc; int ticks; bit seen; logic [7:0] e;
    press(B_CLEAR);
    @(negedge clk);
    dir = 1'b1; limit = 8'd255; auto_reload = 1'b1;
    for (int k = 1; k <= 127; k++) exp_q.push_back(8'(k));
    press(B_START);
    for (int k = 1; k <= 127; k++) begin
      wait_tick(10, cyc, seen);
      total_cnt++; if (!seen) begin $display("[TB] FAIL mid_tick_timeout[%0d]: no tick", k); break; end else pass_cnt++;
      e = exp_q.pop_front();
      total_cnt++; if (count !== e) $display("[TB] FAIL mid_count[%0d]: got %0d expected %0d", k, count, e); else pass_cnt++;
    end
    exp_q.delete();
    total_cnt++; if (count !== 8'h7F) $display("[TB] FAIL mid_reach_7f: got %0h expected 7f", count); else pass_cnt++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total_cnt++; if (count !== 8'd0 || tick !== 1'b0) $display("[TB] FAIL mid_reset_count: count=%0d tick=%b expected 0/0", count, tick); else pass_cnt++;
    total_cnt++; if (running !== 1'b0 || done !== 1'b0) $display("[TB] FAIL mid_reset_state: running=%b done=%b expected 0/0", running, done); else pass_cnt++;
    rst = 1'b0;
    ticks = 0;
    repeat (8) begin @(negedge clk); if (tick) ticks++; end
    total_cnt++; if (ticks !== 0 || running !== 1'b0) $display("[TB] FAIL mid_reset_idle: ticks=%0d running=%b expected 0/0", ticks, running); else pass_cnt++;
  endtask

  initial begin
    $display("[TB] counter_sequencer bench, CLK_DIV=%0d", CLK_DIV);
    test_reset();
    test_run_up();
    test_terminal_stop();
    test_down_count();
    test_pause_step();
    test_simultaneous();
    test_mid_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/counter_sequencer.md
# counter_sequencer

Run/pause/step/clear controller for the board's 8-bit display counter. It replaces the free-running slow-clock counter with an enable-driven counter on the main clock. A built-in prescaler paces the count, and front-panel buttons sequence it through a small state machine with up/down direction and a programmable terminal value. The `count` output feeds the seven-segment display path unchanged.

## Interface
- `CLK_DIV`, default 100_000_000: main-clock cycles per count step; legal range 2 and up.
- `WIDTH`, default 8: counter width.
- `clk` input 1: main system clock; all logic on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `btn_start` input 1: debounced, synchronous level; rising edge = start/resume.
- `btn_stop` input 1: debounced level; rising edge = pause.
- `btn_step` input 1: debounced level; rising edge = single step.
- `btn_clear` input 1: debounced level; rising edge = clear.
- `dir` input 1: 1 = count up, 0 = count down; sampled on every count step.
- `auto_reload` input 1: 1 = wrap at terminal and keep running; 0 = stop in DONE.
- `limit` input WIDTH: terminal value; sampled live.
- `count` output WIDTH: current count.
- `tick` output 1: one-cycle pulse, high in the cycle `count` takes a new value.
- `running` output 1: high while in RUN.
- `done` output 1: high while in DONE.

## Operation
- **Edge detect.** Each button has a registered previous-level flop. Pulse = level & ~prev. A button held high produces one pulse only.
- **Event priority (same cycle).** clear > stop > start > step. Lower-priority pulses in that cycle are discarded.
- **States:**
  - IDLE (reset state).
  - RUN.
  - PAUSE.
  - DONE.
- **IDLE:**
  - start → RUN, with the prescaler at 0.
  - step → one count step, stay IDLE.
- **RUN:**
  - Prescaler increments every cycle.
  - At `CLK_DIV-1`: prescaler returns to 0 and a count step occurs.
  - stop → PAUSE; prescaler value is held.
  - step is ignored.
- **PAUSE:**
  - start → RUN; the prescaler resumes from its held value.
  - step → one count step, stay PAUSE.
- **DONE:**
  - start → reload `count` (0 if `dir`=1, `limit` if `dir`=0), prescaler to 0, → RUN.
  - step is ignored.
- **clear (any state).** `count` = 0, prescaler = 0, → IDLE.
- **Count step, up (`dir`=1):**
  - If `count == limit`, this is terminal: `auto_reload`=1 → `count` = 0; `auto_reload`=0 → `count` held, → DONE.
  - Otherwise `count + 1`, modulo 2^WIDTH. If `count` > `limit`, it passes 255 → 0 and then reaches `limit`.
- **Count step, down (`dir`=0):**
  - If `count == 0`, this is terminal: `auto_reload`=1 → `count` = `limit`; `auto_reload`=0 → `count` held, → DONE.
  - Otherwise `count - 1`.
- **`limit` = 0, up.** Every step is terminal: `count` stays 0; with `auto_reload`=0, DONE follows on the first step.
- **`tick`** asserts on every count step, including steps that wrap or reload. It does not assert on a terminal step that enters DONE, because `count` is unchanged. It does not assert on clear or on a DONE→RUN reload.
- **Reset values.** `count` = 0, `tick` = 0, `running` = 0, `done` = 0, state IDLE, prescaler 0, edge flops 0. Reset mid-RUN aborts immediately with no extra tick.

## Timing
- **Button to action.** Button level rising at edge N → pulse in cycle N → state and `count` update at edge N+1. Button-to-effect latency: 1 cycle after the level is sampled high.
- **Count rate.** In RUN, a count step occurs every `CLK_DIV` cycles. The first step comes `CLK_DIV` cycles after RUN is entered from IDLE or DONE.
- **Outputs.** `tick`, `running`, `done` and `count` are all registered. `running` and `done` follow the state with no combinational path from the inputs.
- **Pause/resume.** Pause then resume preserves the phase: the total RUN cycles between steps equals `CLK_DIV`.

## Structure
- **Package `counter_pkg`:**
  - state enum (`ST_IDLE`, `ST_RUN`, `ST_PAUSE`, `ST_DONE`).
  - `COUNT_W` = 8 default.
  - `PRESC_W` = `$clog2(CLK_DIV)`, as a function.
- **Sub-module `btn_edge`** (level in, one-cycle pulse out). Instantiated four times.
- **Top level.** The FSM, prescaler and count datapath stay in `counter_sequencer`.

## Test plan
All scenarios use `CLK_DIV`=4.
1. **Reset, then run.** Pulse rst; press start with `dir`=1, `limit`=5, `auto_reload`=1 → `count` reads 1,2,3,4,5,0,1 on successive ticks spaced 4 cycles apart; `running`=1.
2. **Terminal stop.** `auto_reload`=0, `limit`=3, run up → `count` stops at 3 with `done`=1, `running`=0. Press start → `count`=0, RUN resumes.
3. **Down count.** `dir`=0, `limit`=9, start at 0 → first tick reloads to 9, then 8, 7. With `auto_reload`=0, count from 2 → 1, 0, then DONE with `count`=0.
4. **Pause and step.** Press stop after 2 prescaler cycles → `count` frozen. Two step presses → `count`+2, each with a tick. Press start → next tick after exactly 2 more cycles.
5. **Simultaneous events.** Clear and start pulses in the same cycle while RUN → `count`=0, IDLE, no tick. Holding start high for 20 cycles yields one start event only.
6. **Mid-operation reset.** Assert rst in RUN with `count`=0x7F, 1 cycle before a tick → next cycle: `count`=0, state IDLE, no tick, all outputs 0.
